// File: rtl/imem_unit_if.sv
// rtl/imem_unit_if.sv - fetch-side request/response and backing-memory read bundle for imem_unit
interface imem_unit_if #(
  parameter int WORD_LENGTH = 32
);
  logic                   reqValid;
  logic [WORD_LENGTH-1:0] reqAddr;
  logic                   reqReady;
  logic                   rspValid;
  logic [WORD_LENGTH-1:0] rspInstr;
  logic                   rspErr;
  logic                   memReq;
  logic [WORD_LENGTH-1:0] memAddr;
  logic                   memAck;
  logic [WORD_LENGTH-1:0] memData;

  modport master (
    output reqValid, reqAddr, memAck, memData,
    input  reqReady, rspValid, rspInstr, rspErr, memReq, memAddr
  );

  modport slave (
    input  reqValid, reqAddr, memAck, memData,
    output reqReady, rspValid, rspInstr, rspErr, memReq, memAddr
  );
endinterface

// File: rtl/imem_unit.sv
// rtl/imem_unit.sv - direct-mapped one-word-per-line instruction cache with blocking refill
module imem_unit #(
  parameter int WORD_LENGTH = 32,
  parameter int INDEX_BITS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  imem_unit_if.slave  bus,
  output logic [15:0] hitCnt,
  output logic [15:0] missCnt
);
  localparam int LINES    = 2 ** INDEX_BITS;
  localparam int TAG_BITS = WORD_LENGTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

  state_t                 state_q, state_d;
  logic [WORD_LENGTH-1:0] addr_q, addr_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic                   flush_pend_q, flush_pend_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [WORD_LENGTH-1:0] rsp_instr_q, rsp_instr_d;
  logic [15:0]            hit_cnt_q, hit_cnt_d;
  logic [15:0]            miss_cnt_q, miss_cnt_d;

  logic [TAG_BITS-1:0]    tag_q  [LINES];
  logic [WORD_LENGTH-1:0] data_q [LINES];

  logic                   line_we;
  logic [INDEX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]    tag;
  logic                   misaligned;
  logic                   hit;
  logic                   idle_like;

  assign idx        = addr_q[INDEX_BITS+1:2];
  assign tag        = addr_q[WORD_LENGTH-1:INDEX_BITS+2];
  assign misaligned = (addr_q[1:0] != 2'b00);
  assign hit        = valid_q[idx] && (tag_q[idx] == tag);
  assign idle_like  = (state_q == IDLE) || (state_q == RESP);

  // rst gates readiness so the fetch stage sees no acceptance while reset is held
  assign bus.reqReady = rst && idle_like && !flush && !flush_pend_q;
  assign bus.rspValid = rsp_valid_q;
  assign bus.rspErr   = rsp_err_q;
  assign bus.rspInstr = rsp_instr_q;
  assign bus.memReq   = (state_q == FILL);
  assign bus.memAddr  = {addr_q[WORD_LENGTH-1:2], 2'b00};
  assign hitCnt       = hit_cnt_q;
  assign missCnt      = miss_cnt_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_instr_d  = rsp_instr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    line_we      = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        if (flush || flush_pend_q) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
          state_d      = IDLE;
        end else if (bus.reqValid) begin
          addr_d  = bus.reqAddr;
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (flush) flush_pend_d = 1'b1;
        if (misaligned) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_instr_d = '0;
          state_d     = RESP;
        end else if (hit) begin
          rsp_valid_d = 1'b1;
          rsp_instr_d = data_q[idx];
          if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
          state_d     = RESP;
        end else begin
          if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
          state_d = FILL;
        end
      end
      FILL: begin
        // a flush arriving here is deferred; the line is still installed
        if (flush) flush_pend_d = 1'b1;
        if (bus.memAck) begin
          line_we      = 1'b1;
          valid_d[idx] = 1'b1;
          rsp_valid_d  = 1'b1;
          rsp_instr_d  = bus.memData;
          state_d      = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_instr_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_instr_q  <= rsp_instr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // tag/data arrays need no reset: the valid bits alone qualify them
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= bus.memData;
    end
  end
endmodule

// File: tb/tb_imem_unit.sv
// tb/tb_imem_unit.sv - randomized self-checking bench for imem_unit against a line-table reference model
module tb_imem_unit;
  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] hitCnt;
  logic [15:0] missCnt;

  imem_unit_if #(.WORD_LENGTH(32)) bus ();

  imem_unit #(.WORD_LENGTH(32), .INDEX_BITS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .bus     (bus),
    .hitCnt  (hitCnt),
    .missCnt (missCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // reference cache: one entry per index, plus counters and last delivered word
  bit          mv [16];
  logic [25:0] mt [16];
  logic [31:0] md [16];
  int          m_hits;
  int          m_misses;
  logic [31:0] m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 16; j++) mv[j] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
    m_last   = '0;
  endtask

  task automatic model_invalidate();
    for (int j = 0; j < 16; j++) mv[j] = 1'b0;
  endtask

  // mode 0: plain fetch, 1: flush pulsed during FILL, 2: reset pulsed during FILL
  task automatic fetch(input logic [31:0] a, input logic [31:0] fill_data, input int delay, input int mode);
    int          k;
    int          i;
    bit          aligned;
    bit          miss;
    logic [25:0] t;
    logic [31:0] exp_instr;
    aligned = (a[1:0] == 2'b00);
    i       = int'(a[5:2]);
    t       = a[31:6];
    miss    = aligned && !(mv[i] && mt[i] == t);
    #1;
    bus.reqValid = 1'b1;
    bus.reqAddr  = a;
    k = 0;
    while (!bus.reqReady && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.reqValid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.reqValid = 1'b0;
    check("lookup_rsp_valid", {31'd0, bus.rspValid}, 32'd0);
    @(negedge clk);
    if (!miss) begin
      exp_instr = aligned ? md[i] : 32'd0;
      check("rsp_valid", {31'd0, bus.rspValid}, 32'd1);
      check("rsp_err", {31'd0, bus.rspErr}, {31'd0, !aligned});
      check("rsp_instr", bus.rspInstr, exp_instr);
      check("no_mem_req", {31'd0, bus.memReq}, 32'd0);
      if (aligned && m_hits < 65535) m_hits++;
      m_last = exp_instr;
    end else begin
      if (m_misses < 65535) m_misses++;
      check("mem_req", {31'd0, bus.memReq}, 32'd1);
      check("mem_addr", bus.memAddr, {a[31:2], 2'b00});
      if (mode == 2) begin
        rst = 1'b0;
        #1;
        check("rst_mem_req", {31'd0, bus.memReq}, 32'd0);
        check("rst_ready", {31'd0, bus.reqReady}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rspValid}, 32'd0);
        check("rst_rsp_instr", bus.rspInstr, 32'd0);
        check("rst_mem_addr", bus.memAddr, 32'd0);
        check("rst_miss_cnt", {16'd0, missCnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_ready", {31'd0, bus.reqReady}, 32'd1);
        @(negedge clk);
        bus.memAck  = 1'b1;
        bus.memData = fill_data;
        @(negedge clk);
        bus.memAck = 1'b0;
        #1;
        check("late_ack_rsp_valid", {31'd0, bus.rspValid}, 32'd0);
        check("late_ack_mem_req", {31'd0, bus.memReq}, 32'd0);
        check("late_ack_instr", bus.rspInstr, 32'd0);
        model_reset();
        return;
      end
      if (mode == 1) flush = 1'b1;
      for (int d = 0; d < delay; d++) begin
        @(negedge clk);
        flush = 1'b0;
      end
      if (delay > 0) check("mem_addr_hold", {31'd0, bus.memReq} ^ bus.memAddr, 32'd1 ^ {a[31:2], 2'b00});
      if (mode == 1) check("ready_in_fill", {31'd0, bus.reqReady}, 32'd0);
      bus.memAck  = 1'b1;
      bus.memData = fill_data;
      @(negedge clk);
      bus.memAck = 1'b0;
      flush      = 1'b0;
      check("fill_rsp_valid", {31'd0, bus.rspValid}, 32'd1);
      check("fill_rsp_err", {31'd0, bus.rspErr}, 32'd0);
      check("fill_rsp_instr", bus.rspInstr, fill_data);
      check("fill_mem_req_drop", {31'd0, bus.memReq}, 32'd0);
      mv[i]  = 1'b1;
      mt[i]  = t;
      md[i]  = fill_data;
      m_last = fill_data;
    end
    check("hit_cnt", {16'd0, hitCnt}, 32'(m_hits));
    check("miss_cnt", {16'd0, missCnt}, 32'(m_misses));
    if (mode == 1 && miss) begin
      check("ready_flush_pending", {31'd0, bus.reqReady}, 32'd0);
      model_invalidate();
      @(negedge clk);
      check("ready_after_flush", {31'd0, bus.reqReady}, 32'd1);
      check("idle_rsp_valid", {31'd0, bus.rspValid}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    n_tests      = 0;
    n_fail       = 0;
    flush        = 1'b0;
    bus.reqValid = 1'b0;
    bus.reqAddr  = '0;
    bus.memAck   = 1'b0;
    bus.memData  = '0;
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #3;
    check("reset_ready", {31'd0, bus.reqReady}, 32'd0);
    check("reset_rsp_valid", {31'd0, bus.rspValid}, 32'd0);
    check("reset_rsp_err", {31'd0, bus.rspErr}, 32'd0);
    check("reset_rsp_instr", bus.rspInstr, 32'd0);
    check("reset_mem_req", {31'd0, bus.memReq}, 32'd0);
    check("reset_mem_addr", bus.memAddr, 32'd0);
    check("reset_counters", {hitCnt, missCnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("first_ready", {31'd0, bus.reqReady}, 32'd1);

    fetch(32'h0000_1000, 32'hDEAD_BEEF, 3, 0);
    fetch(32'h0000_1000, 32'h0, 0, 0);
    fetch(32'h0000_1040, 32'h1234_5678, 1, 0);
    fetch(32'h0000_1000, 32'hDEAD_BEEF, 2, 0);
    check("conflict_miss_cnt", {16'd0, missCnt}, 32'd3);
    fetch(32'h0000_1002, 32'h0, 0, 0);
    fetch(32'h0000_1080, 32'hCAFE_F00D, 2, 1);
    fetch(32'h0000_1080, 32'h0BAD_CAFE, 1, 0);
    fetch(32'h0000_1000, 32'hDEAD_BEEF, 2, 2);
    fetch(32'h0000_1000, 32'h5555_AAAA, 0, 0);

    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        #1;
        flush = 1'b1;
        #1;
        check("flush_ready", {31'd0, bus.reqReady}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        model_invalidate();
        #1;
        check("post_flush_ready", {31'd0, bus.reqReady}, 32'd1);
      end else if (r == 1) begin
        #1;
        bus.memAck  = 1'b1;
        bus.memData = $urandom;
        @(negedge clk);
        bus.memAck = 1'b0;
        #1;
        check("stray_ack_rsp_valid", {31'd0, bus.rspValid}, 32'd0);
        check("stray_ack_mem_req", {31'd0, bus.memReq}, 32'd0);
        check("hold_rsp_instr", bus.rspInstr, m_last);
      end else begin
        a = 32'h0000_2000 + 32'($urandom_range(0, 3)) * 32'd64 + 32'($urandom_range(0, 15)) * 32'd4;
        if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
        fetch(a, $urandom, int'($urandom_range(0, 4)), ($urandom_range(0, 14) == 0) ? 1 : 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
